// File: rtl/bus_cycle_initiator.sv
// rtl/bus_cycle_initiator.sv - T1-T4 bus cycle master for the multiplexed address/data peripheral bus.
// All bus pins are registered and set on the edge that enters their phase, so READY/req never reach a pin combinationally.
module bus_cycle_initiator #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 15
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     req,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic                     busy,
  output logic                     ack,
  output logic                     err,
  output logic [DATA_W-1:0]        rdata,
  output logic                     ALE,
  output logic                     RD_n,
  output logic                     WR_n,
  output logic [ADDR_W-DATA_W-1:0] A,
  output logic [DATA_W-1:0]        AD_out,
  output logic                     AD_oe,
  input  logic [DATA_W-1:0]        AD_in,
  input  logic                     READY
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_T3,
    S_TW,
    S_T4
  } state_t;

  state_t                    r_state;
  logic                      r_we;
  logic [DATA_W-1:0]         r_wdata;
  logic [WAIT_W-1:0]         r_wait;
  logic                      r_busy;
  logic                      r_ack;
  logic                      r_err;
  logic [DATA_W-1:0]         r_rdata;
  logic                      r_ale;
  logic                      r_rd_n;
  logic                      r_wr_n;
  logic [ADDR_W-DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]         r_ad_out;
  logic                      r_ad_oe;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_wdata  <= '0;
      r_wait   <= '0;
      r_busy   <= 1'b0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_ale    <= 1'b0;
      r_rd_n   <= 1'b1;
      r_wr_n   <= 1'b1;
      r_a      <= '0;
      r_ad_out <= '0;
      r_ad_oe  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_state  <= S_T1;
            r_we     <= we;
            r_wdata  <= wdata;
            r_busy   <= 1'b1;
            r_ale    <= 1'b1;
            r_ad_oe  <= 1'b1;
            r_ad_out <= addr[DATA_W-1:0];
            r_a      <= addr[ADDR_W-1:DATA_W];
          end
        end

        S_T1: begin
          r_state <= S_T2;
          r_ale   <= 1'b0;
          if (r_we) begin
            r_ad_oe  <= 1'b1;
            r_ad_out <= r_wdata;
            r_wr_n   <= 1'b0;
          end else begin
            r_ad_oe <= 1'b0;
            r_rd_n  <= 1'b0;
          end
        end

        S_T2: begin
          r_state <= S_T3;
        end

        S_T3: begin
          if (READY) begin
            r_state <= S_T4;
            r_rd_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_ack   <= 1'b1;
            r_err   <= 1'b0;
            if (!r_we) r_rdata <= AD_in;
          end else begin
            r_state <= S_TW;
            r_wait  <= '0;
          end
        end

        // READY wins over the timeout when both land on the last wait state.
        S_TW: begin
          if (READY) begin
            r_state <= S_T4;
            r_rd_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_ack   <= 1'b1;
            r_err   <= 1'b0;
            if (!r_we) r_rdata <= AD_in;
          end else if (r_wait == WAIT_LAST) begin
            r_state <= S_T4;
            r_rd_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_ack   <= 1'b1;
            r_err   <= 1'b1;
            if (!r_we) r_rdata <= '1;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end

        S_T4: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_ack    <= 1'b0;
          r_err    <= 1'b0;
          r_ad_oe  <= 1'b0;
          r_ad_out <= '0;
          r_a      <= '0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_ale   <= 1'b0;
          r_rd_n  <= 1'b1;
          r_wr_n  <= 1'b1;
          r_ad_oe <= 1'b0;
          r_a     <= '0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign ack    = r_ack;
  assign err    = r_err;
  assign rdata  = r_rdata;
  assign ALE    = r_ale;
  assign RD_n   = r_rd_n;
  assign WR_n   = r_wr_n;
  assign A      = r_a;
  assign AD_out = r_ad_out;
  assign AD_oe  = r_ad_oe;

endmodule

// File: tb/tb_bus_cycle_initiator.sv
// tb/tb_bus_cycle_initiator.sv - directed and randomized bus cycle checks against a cycle-count reference model.
module tb_bus_cycle_initiator;

  localparam int ADDR_W   = 20;
  localparam int DATA_W   = 8;
  localparam int MAX_WAIT = 15;

  logic                     CLK = 1'b0;
  logic                     RESET;
  logic                     req;
  logic                     we;
  logic [ADDR_W-1:0]        addr;
  logic [DATA_W-1:0]        wdata;
  logic                     busy;
  logic                     ack;
  logic                     err;
  logic [DATA_W-1:0]        rdata;
  logic                     ALE;
  logic                     RD_n;
  logic                     WR_n;
  logic [ADDR_W-DATA_W-1:0] A;
  logic [DATA_W-1:0]        AD_out;
  logic                     AD_oe;
  logic [DATA_W-1:0]        AD_in;
  logic                     READY;

  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] model_rdata;

  bus_cycle_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .RESET(RESET), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy), .ack(ack), .err(err), .rdata(rdata), .ALE(ALE), .RD_n(RD_n),
    .WR_n(WR_n), .A(A), .AD_out(AD_out), .AD_oe(AD_oe), .AD_in(AD_in), .READY(READY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ale"},  32'(ALE),   32'd0);
    check({tag, "_rdn"},  32'(RD_n),  32'd1);
    check({tag, "_wrn"},  32'(WR_n),  32'd1);
    check({tag, "_oe"},   32'(AD_oe), 32'd0);
    check({tag, "_a"},    32'(A),     32'd0);
    check({tag, "_busy"}, 32'(busy),  32'd0);
    check({tag, "_ack"},  32'(ack),   32'd0);
  endtask

  // One transfer: n_low is the number of READY-low cycles counted from T3.
  // Cycle 0 is the accepting IDLE cycle; the model places T4 at 4 + min(n_low, MAX_WAIT).
  task automatic run_txn(input string tag, input logic t_we, input logic [ADDR_W-1:0] t_addr,
                         input logic [DATA_W-1:0] t_wdata, input int n_low,
                         input logic [DATA_W-1:0] t_rd, input int reset_at);
    int   waits;
    int   last;
    logic t_err;
    logic exp_rd_n;
    logic exp_wr_n;
    logic exp_oe;
    waits = (n_low > MAX_WAIT) ? MAX_WAIT : n_low;
    t_err = (n_low > MAX_WAIT);
    last  = 4 + waits;

    @(negedge CLK);
    check_idle({tag, "_pre"});
    req   = 1'b1;
    we    = t_we;
    addr  = t_addr;
    wdata = t_wdata;
    READY = 1'($urandom);
    AD_in = DATA_W'($urandom);

    for (int k = 1; k <= last; k++) begin
      @(negedge CLK);
      if (k == reset_at) begin
        RESET = 1'b1;
        req   = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        model_rdata = '0;
        check_idle({tag, "_rst"});
        check({tag, "_rst_err"},   32'(err),    32'd0);
        check({tag, "_rst_rdata"}, 32'(rdata),  32'd0);
        check({tag, "_rst_adout"}, 32'(AD_out), 32'd0);
        return;
      end

      exp_rd_n = !(!t_we && k >= 2 && k < last);
      exp_wr_n = !( t_we && k >= 2 && k < last);
      exp_oe   = t_we ? 1'b1 : (k == 1);
      check($sformatf("%s_c%0d_ale", tag, k),  32'(ALE),   32'(k == 1));
      check($sformatf("%s_c%0d_rdn", tag, k),  32'(RD_n),  32'(exp_rd_n));
      check($sformatf("%s_c%0d_wrn", tag, k),  32'(WR_n),  32'(exp_wr_n));
      check($sformatf("%s_c%0d_oe", tag, k),   32'(AD_oe), 32'(exp_oe));
      check($sformatf("%s_c%0d_a", tag, k),    32'(A),     32'(t_addr[ADDR_W-1:DATA_W]));
      check($sformatf("%s_c%0d_busy", tag, k), 32'(busy),  32'd1);
      check($sformatf("%s_c%0d_ack", tag, k),  32'(ack),   32'(k == last));
      if (exp_oe)
        check($sformatf("%s_c%0d_adout", tag, k), 32'(AD_out),
              (k == 1) ? 32'(t_addr[DATA_W-1:0]) : 32'(t_wdata));
      if (k == last) begin
        if (!t_we) model_rdata = t_err ? '1 : t_rd;
        check({tag, "_err"}, 32'(err), 32'(t_err));
        if (!t_we) check({tag, "_rdata"}, 32'(rdata), 32'(model_rdata));
      end

      // Requests during the cycle must be ignored; bus-side inputs follow the wait plan.
      req   = (k == last) ? 1'b0 : ((k == 2) ? 1'b1 : 1'($urandom));
      we    = 1'($urandom);
      addr  = ADDR_W'($urandom);
      wdata = DATA_W'($urandom);
      READY = !(k >= 3 && k < 3 + n_low);
      AD_in = (k == 3 + n_low) ? t_rd : DATA_W'($urandom);
    end
  endtask

  initial begin
    int   sel;
    int   n_low;
    RESET = 1'b1;
    req   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    AD_in = '0;
    READY = 1'b1;
    model_rdata = '0;
    repeat (2) @(negedge CLK);
    check_idle("reset");
    check("reset_err",   32'(err),    32'd0);
    check("reset_rdata", 32'(rdata),  32'd0);
    check("reset_adout", 32'(AD_out), 32'd0);
    RESET = 1'b0;

    run_txn("wr_nowait", 1'b1, 20'hA5C3F, 8'h5A, 0, 8'h00, 0);
    run_txn("rd_nowait", 1'b0, 20'h00012, 8'h00, 0, 8'hC7, 0);
    run_txn("rd_wait2",  1'b0, 20'h3_4567, 8'h00, 2, 8'h81, 0);
    run_txn("rd_tmo",    1'b0, 20'hF_0F0F, 8'h00, 40, 8'h11, 0);
    run_txn("wr_tmo",    1'b0 ^ 1'b1, 20'h1_2345, 8'h77, 16, 8'h22, 0);
    run_txn("rd_edge15", 1'b0, 20'h5_5555, 8'h00, 15, 8'h3C, 0);
    run_txn("wr_ovl",    1'b1, 20'hC_3210, 8'hE1, 0, 8'h00, 0);
    run_txn("rd_rst",    1'b0, 20'h8_8888, 8'h00, 30, 8'h44, 6);
    run_txn("rd_after",  1'b0, 20'h0_00FF, 8'h00, 1, 8'h9D, 0);

    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       n_low = 0;
        1:       n_low = $urandom_range(1, 4);
        2:       n_low = $urandom_range(13, 17);
        default: n_low = $urandom_range(0, 20);
      endcase
      run_txn($sformatf("rnd%0d", i), 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom),
              n_low, DATA_W'($urandom), 0);
    end

    @(negedge CLK);
    check_idle("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_cycle_initiator.md
Name: bus_cycle_initiator

Overview:
- Bus master for the multiplexed address/data peripheral bus.
- Converts a single-word request from the local controller into a complete T1–T4 bus cycle.
- T1: drives `ALE` and the address on `AD`/`A`. T2–T3: asserts active-low `RD_n` or `WR_n`.
- Inserts wait states while `READY` is low and returns read data with a one-cycle `ack`.
- Drives the same `ALE`/`RD`/`WR`/`AD` pins that the slave-side bus FSMs decode.

Parameters:
- `ADDR_W`, 20, total address width; `AD` carries `addr[DATA_W-1:0]` and `A` carries `addr[ADDR_W-1:DATA_W]`.
- `DATA_W`, 8, data width of the multiplexed `AD` bus.
- `MAX_WAIT`, 15, maximum wait states before a cycle is forced to complete with `err`.

Ports:
- `CLK` input 1: clock; all logic on the rising edge.
- `RESET` input 1: synchronous, active-high reset. Clock is `CLK`.
- `req` input 1: transfer request; sampled only when `busy`=0.
- `we` input 1: 1 = write, 0 = read; latched with `req`.
- `addr` input `ADDR_W`: transfer address; latched with `req`.
- `wdata` input `DATA_W`: write data; latched with `req`.
- `busy` output 1: high from the cycle after accept through T4.
- `ack` output 1: one-cycle completion pulse, asserted in T4.
- `err` output 1: valid with `ack`; 1 = wait-state timeout.
- `rdata` output `DATA_W`: read data, valid while `ack`=1 on reads, held until the next read.
- `ALE` output 1: address latch enable, active high.
- `RD_n` output 1: read strobe, active low.
- `WR_n` output 1: write strobe, active low.
- `A` output `ADDR_W-DATA_W`: upper address bits.
- `AD_out` output `DATA_W`: multiplexed address/data drive value.
- `AD_oe` output 1: `AD` output enable; the top level builds the tristate.
- `AD_in` input `DATA_W`: sampled `AD` bus.
- `READY` input 1: slave ready; low inserts wait states.

Behaviour:
- **Reset** (synchronous): state=IDLE, `ALE`=0, `RD_n`=1, `WR_n`=1, `AD_oe`=0, `AD_out`=0, `A`=0, `busy`=0, `ack`=0, `err`=0, `rdata`=0, wait counter=0.
- **Reset mid-cycle:** immediate return to IDLE at the next edge, strobes deasserted, no `ack`.
- **Output timing:** bus outputs are Moore, decoded from the state register and the latched request only. There is no combinational path from `req`/`READY` to the bus pins.
- **IDLE:**
  - All strobes inactive, `AD_oe`=0.
  - `req`=1 latches `addr`/`we`/`wdata` and moves to T1.
- **T1:**
  - `busy`=1, `ALE`=1.
  - `AD_oe`=1, `AD_out`=`addr[DATA_W-1:0]`, `A`=upper address bits.
  - Always moves to T2.
- **T2:**
  - `ALE`=0.
  - Read: `AD_oe`=0, `RD_n`=0.
  - Write: `AD_oe`=1, `AD_out`=`wdata`, `WR_n`=0.
  - Always moves to T3.
- **T3:**
  - Strobes and `AD` held as in T2.
  - `READY`=1: on a read, capture `AD_in` into `rdata` at this edge; go to T4.
  - `READY`=0: clear the wait counter; go to TW.
- **TW:**
  - Strobes and `AD` held; wait counter increments each cycle.
  - `READY`=1: capture `AD_in` if read; go to T4.
  - Counter reaches `MAX_WAIT` with `READY` still 0: set the timeout flag; go to T4. On a timed-out read, `rdata` is all ones.
- **T4:**
  - `RD_n`=1, `WR_n`=1 (the rising strobe edge ends the slave's access).
  - Write: `AD_oe`=1, `AD_out`=`wdata` held for data hold time. Read: `AD_oe`=0.
  - `ack`=1 for exactly this cycle; `err`=timeout flag.
  - Always moves to IDLE.
- **Address stability:** `A` is stable from T1 through T4. `A` returns to 0 in IDLE.
- **Latency:** `req` accepted at edge n → T1 at n+1, T2 n+2, T3 n+3, T4/`ack` n+4, IDLE n+5. Each wait state adds 1 cycle. Minimum spacing between accepts is 5 cycles.
- **Requests while busy:** `req` while `busy`=1 is ignored and not queued. Inputs `addr`/`wdata`/`we` may change freely after accept.
- **Strobe exclusivity:** `RD_n` and `WR_n` are never both low. `ALE` is never high while either strobe is low.

Test Plan:
- **Write, no wait:** `req`=1, `we`=1, `addr`=20'hA5C3F, `wdata`=8'h5A, `READY`=1.
  - T1: `ALE`=1, `AD_out`=8'h3F, `A`=12'hA5C.
  - T2–T3: `WR_n`=0, `AD_out`=8'h5A.
  - `ack`=1, `err`=0 exactly 4 cycles after accept; `RD_n` stays 1.
- **Read, no wait:** `we`=0, `addr`=20'h00012, `AD_in`=8'hC7 in T3.
  - `AD_oe`=0 in T2–T4, `RD_n`=0 in T2–T3.
  - `ack` at +4 with `rdata`=8'hC7.
- **Read, two wait states:** `READY`=0 for 2 cycles after entering T3, then 1, with `AD_in`=8'h81.
  - `RD_n` low for 4 cycles; `ack` at +6 with `rdata`=8'h81.
- **Timeout:** `READY` held 0 on a read.
  - `ack`=1, `err`=1, `rdata`=8'hFF after `MAX_WAIT` wait states (+19 with defaults).
  - `RD_n` returns to 1.
- **Overlap and reset:**
  - Second `req` asserted during T2 of a write: ignored, single `ack`, no second `ALE`.
  - `RESET` pulsed during TW: next cycle is IDLE, all strobes inactive, `busy`=0, no `ack`.
